pixel_allocator: RTL and testbench
==================================

Name: pixel_allocator

Overview:
- Consumer stage directly downstream of the image broadcast stage; one instance per output pixel in flight.
- Snoops the broadcast pixel stream (en, x, y, data) and captures only pixels inside its armed filter window.
- Multiplies each captured pixel by the matching filter weight and accumulates across all taps and all z-levels.
- Presents one convolution result per armed window via a valid/ready handshake; back-pressures the broadcast stage through `block_req`.

Parameters:
- DATA_W, 18, pixel and weight width (signed two's complement)
- ACC_W, 48, accumulator width
- WADDR_W, 14, weight address width (tap + z*k*k)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- arm  in  1  one-cycle pulse; latches a new target window
- center_x  in  8  window centre x (padded coordinates)
- center_y  in  8  window centre y (padded coordinates)
- radius  in  2  filter half-width: 0 = 1x1, 1 = 3x3, 2 = 5x5; 3 is illegal and is treated as 2
- issue_en  in  1  broadcast pixel valid
- issue_x  in  8  broadcast current_x
- issue_y  in  8  broadcast current_y
- issue_data  in  DATA_W  broadcast current_data
- issue_round  in  1  broadcast round-complete flag
- weight_addr  out  WADDR_W  combinational tap address
- weight_data  in  DATA_W  weight at weight_addr, same cycle (register-file read)
- block_req  out  1  request that the broadcast stage stall
- result  out  ACC_W  accumulated result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all state registers, z counter and accumulator = 0; FSM = IDLE; result_valid = 0, block_req = 0, busy = 0, result = 0.
- FSM states: IDLE, ARMED, DRAIN, HOLD.
- IDLE:
  - arm latches cx, cy, r (clamped per radius rule) and clears acc and z → ARMED.
  - arm in any other state is ignored.
- Match (ARMED only): `hit = issue_en & |issue_x - cx| <= r & |issue_y - cy| <= r`.
  - Unsigned 9-bit compare; no wrap-around at 0 or 255.
- Tap address: `dx = issue_x - cx + r`, `dy = issue_y - cy + r`, `k = 2r + 1`.
  - `weight_addr = z*k*k + dy*k + dx`, truncated to WADDR_W.
- Pipeline, 2 stages:
  - S1 registers `hit` and `issue_data*weight_data` (2*DATA_W signed product).
  - S2 does `acc += sign-extend(product)` when S1 hit is valid.
  - Latency: issue beat to acc update = 2 cycles.
- z counter increments in the cycle a hit has `dx == 2r` and `dy == 2r` (last tap of a z-level).
- ARMED → DRAIN on `issue_round == 1`.
  - A hit presented in the same cycle as issue_round is still accumulated.
- DRAIN waits 2 cycles for the pipeline to empty, then → HOLD with result_valid = 1.
- HOLD:
  - result is stable while result_valid = 1.
  - `result_valid & result_ready` → IDLE next cycle.
  - arm and ready in the same cycle: the result is accepted and arm is ignored.
- block_req = 1 in HOLD only, so the broadcast stage does not advance to the next round before the result is consumed.
- Accumulation wraps modulo 2^ACC_W unless the optional feature below is compiled in.
- Async reset mid-operation: return to IDLE immediately; any partial accumulation is discarded; result_valid deasserts asynchronously.
- issue_en = 0 beats never match.
- Duplicate x,y within one z-level are accumulated again; avoiding them is the upstream stage's responsibility.

Optional Feature:
- Macro: `PIXEL_ALLOCATOR_SATURATE_EN`.
- Defined:
  - Accumulator add saturates at signed ACC_W min/max.
  - On entry to HOLD, result is clamped to the signed DATA_W range, then sign-extended to ACC_W.
  - Extra output `sat_flag` (1 bit, reset 0) is set if any clamp occurred in the round and cleared on arm.
- Undefined: wrap-around arithmetic, no clamp, `sat_flag` port absent.

Decomposition:
- Shared package `conv_pkg`:
  - constants PIX_DATA_W = 18, COORD_W = 8, RADIUS_MAX = 2
  - FSM state encoding: IDLE = 0, ARMED = 1, DRAIN = 2, HOLD = 3
  - ACC_W default
- Sub-module `tap_match`: combinational window hit detection and dx/dy/weight_addr generation, reusable by future allocator variants.
- MAC pipeline and FSM stay in pixel_allocator.

Test Plan:
- 1x1 basic: arm cx = 5, cy = 5, r = 0; stream (5,5,data 3) with weight 4 on z0 and (5,5,data 2) with weight 4 on z1; pulse round → result = 20 at 2 cycles after DRAIN entry; block_req = 1 until ready.
- 3x3 with padding: arm cx = 1, cy = 1, r = 1; stream x,y 0..2 with data = 0 on row 0 and column 0 (padding), 1 elsewhere; all weights 1 → result = 4; weight_addr sequence 0..8.
- Out-of-window filtering: arm cx = 10, cy = 10, r = 1; stream full rows 8..12 with data = 1 and weights = 1 → result = 9; z = 1 after the last tap.
- Handshake hold: result_ready held 0 for 5 cycles → result stable and result_valid = 1 throughout; assert ready → IDLE next cycle; arm during HOLD is ignored.
- Reset mid-round: arm, inject 3 hits, assert rst asynchronously between clock edges → outputs 0 immediately; re-arm and run → result excludes the earlier hits.
- Saturation (`PIXEL_ALLOCATOR_SATURATE_EN`): data = 0x1FFFF, weight = 0x1FFFF over 9 taps → result = 131071 and sat_flag = 1; without the macro, result equals the exact 48-bit sum.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution allocator family.
package conv_pkg;
   localparam int PIX_DATA_W = 18;
   localparam int COORD_W    = 8;
   localparam int RADIUS_MAX = 2;
   localparam int ACC_W_DEF  = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;
endpackage

// File: rtl/tap_match.sv
// Combinational filter-window hit detection and weight tap address generation.
module tap_match
   import conv_pkg::*;
#(
   parameter int WADDR_W = 14
) (
   input  logic               en,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [1:0]         r,
   input  logic [WADDR_W-1:0] z,
   output logic               hit,
   output logic               last,
   output logic [WADDR_W-1:0] addr
);
   logic [COORD_W:0]   w_r9, w_adx, w_ady, w_dx, w_dy, w_two_r;
   logic [WADDR_W-1:0] w_k;

   assign w_r9    = {{(COORD_W-1){1'b0}}, r};
   assign w_two_r = {{(COORD_W-2){1'b0}}, r, 1'b0};

   // 9-bit magnitudes so a window near 0 or 255 never wraps to the far edge
   assign w_adx = (x >= cx) ? {1'b0, x} - {1'b0, cx} : {1'b0, cx} - {1'b0, x};
   assign w_ady = (y >= cy) ? {1'b0, y} - {1'b0, cy} : {1'b0, cy} - {1'b0, y};
   assign hit   = en & (w_adx <= w_r9) & (w_ady <= w_r9);

   assign w_dx = {1'b0, x} - {1'b0, cx} + w_r9;
   assign w_dy = {1'b0, y} - {1'b0, cy} + w_r9;
   assign w_k  = WADDR_W'({r, 1'b1});

   assign last = hit & (w_dx == w_two_r) & (w_dy == w_two_r);
   assign addr = z * w_k * w_k + WADDR_W'(w_dy) * w_k + WADDR_W'(w_dx);
endmodule

// File: rtl/pixel_allocator.sv
// Window-filtered MAC consumer of the pixel broadcast stream with valid/ready result.
// Optional PIXEL_ALLOCATOR_SATURATE_EN: saturating accumulate, DATA_W result clamp, sat_flag.
module pixel_allocator
   import conv_pkg::*;
#(
   parameter int DATA_W  = PIX_DATA_W,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int WADDR_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic [7:0]         center_x,
   input  logic [7:0]         center_y,
   input  logic [1:0]         radius,
   input  logic               issue_en,
   input  logic [7:0]         issue_x,
   input  logic [7:0]         issue_y,
   input  logic [DATA_W-1:0]  issue_data,
   input  logic               issue_round,
   output logic [WADDR_W-1:0] weight_addr,
   input  logic [DATA_W-1:0]  weight_data,
   output logic               block_req,
   output logic [ACC_W-1:0]   result,
   output logic               result_valid,
   input  logic               result_ready,
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
   output logic               sat_flag,
`endif
   output logic               busy
);
   state_t               r_state;
   logic [7:0]           r_cx, r_cy;
   logic [1:0]           r_r;
   logic [WADDR_W-1:0]   r_z;
   logic [ACC_W-1:0]     r_acc;
   logic                 r_s1_hit;
   logic [2*DATA_W-1:0]  r_s1_prod;
   logic                 r_drain;

   logic                 w_tm_hit, w_last, w_hit, w_arm_go;
   logic [2*DATA_W-1:0]  w_prod;
   logic [ACC_W-1:0]     w_prod_ext, w_sum, w_acc_nxt, w_final;

   tap_match #(.WADDR_W(WADDR_W)) u_tap (
      .en   (issue_en),
      .x    (issue_x),
      .y    (issue_y),
      .cx   (r_cx),
      .cy   (r_cy),
      .r    (r_r),
      .z    (r_z),
      .hit  (w_tm_hit),
      .last (w_last),
      .addr (weight_addr)
   );

   assign w_hit      = w_tm_hit & (r_state == ARMED);
   assign w_arm_go   = arm & (r_state == IDLE);
   assign w_prod     = $signed(issue_data) * $signed(weight_data);
   assign w_prod_ext = {{(ACC_W-2*DATA_W){r_s1_prod[2*DATA_W-1]}}, r_s1_prod};
   assign w_sum      = r_acc + w_prod_ext;

`ifdef PIXEL_ALLOCATOR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] L_DMAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] L_DMIN = -L_DMAX - 1;
   logic r_acc_sat, w_ovf, w_clamp_hi, w_clamp_lo;

   assign w_ovf      = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) & (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
   assign w_acc_nxt  = !w_ovf ? w_sum :
                       r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   assign w_clamp_hi = $signed(r_acc) > L_DMAX;
   assign w_clamp_lo = $signed(r_acc) < L_DMIN;
   assign w_final    = w_clamp_hi ? L_DMAX : w_clamp_lo ? L_DMIN : r_acc;
`else
   assign w_acc_nxt  = w_sum;
   assign w_final    = r_acc;
`endif

   // S1 registers hit/product, S2 folds it into the accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_hit  <= 1'b0;
         r_s1_prod <= '0;
         r_acc     <= '0;
         r_z       <= '0;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
         r_acc_sat <= 1'b0;
`endif
      end else begin
         r_s1_hit  <= w_hit;
         r_s1_prod <= w_prod;
         if (w_arm_go) begin
            r_acc <= '0;
            r_z   <= '0;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
            r_acc_sat <= 1'b0;
`endif
         end else begin
            if (r_s1_hit) begin
               r_acc <= w_acc_nxt;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
               if (w_ovf) r_acc_sat <= 1'b1;
`endif
            end
            if (w_hit && w_last) r_z <= r_z + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cx         <= '0;
         r_cy         <= '0;
         r_r          <= '0;
         r_drain      <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         block_req    <= 1'b0;
         busy         <= 1'b0;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
         sat_flag     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (arm) begin
               r_cx    <= center_x;
               r_cy    <= center_y;
               r_r     <= (radius > 2'(RADIUS_MAX)) ? 2'(RADIUS_MAX) : radius;
               r_state <= ARMED;
               busy    <= 1'b1;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
               sat_flag <= 1'b0;
`endif
            end
            ARMED: if (issue_round) begin
               r_state <= DRAIN;
               r_drain <= 1'b0;
            end
            DRAIN: begin
               r_drain <= 1'b1;
               if (r_drain) begin
                  r_state      <= HOLD;
                  result       <= w_final;
                  result_valid <= 1'b1;
                  block_req    <= 1'b1;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
                  sat_flag     <= r_acc_sat | w_clamp_hi | w_clamp_lo;
`endif
               end
            end
            HOLD: if (result_ready) begin
               r_state      <= IDLE;
               result_valid <= 1'b0;
               block_req    <= 1'b0;
               busy         <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_allocator.sv
// Directed self-checking bench for pixel_allocator (honours PIXEL_ALLOCATOR_SATURATE_EN).
module tb_pixel_allocator;
   logic        clk = 1'b0;
   logic        rst;
   logic        arm;
   logic [7:0]  center_x, center_y;
   logic [1:0]  radius;
   logic        issue_en;
   logic [7:0]  issue_x, issue_y;
   logic [17:0] issue_data;
   logic        issue_round;
   logic [13:0] weight_addr;
   logic [17:0] weight_data;
   logic        block_req;
   logic [47:0] result;
   logic        result_valid;
   logic        result_ready;
   logic        busy;
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
   logic        sat_flag;
`endif

   logic [17:0] wmem [0:63];
   int n_pass = 0;
   int n_chk  = 0;

   assign weight_data = wmem[weight_addr[5:0]];

   always #5 clk = ~clk;

   pixel_allocator dut (
      .clk(clk), .rst(rst), .arm(arm),
      .center_x(center_x), .center_y(center_y), .radius(radius),
      .issue_en(issue_en), .issue_x(issue_x), .issue_y(issue_y),
      .issue_data(issue_data), .issue_round(issue_round),
      .weight_addr(weight_addr), .weight_data(weight_data),
      .block_req(block_req), .result(result), .result_valid(result_valid),
      .result_ready(result_ready),
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
      .sat_flag(sat_flag),
`endif
      .busy(busy)
   );

   task automatic wfill(input int mode, input logic [17:0] v);
      for (int i = 0; i < 64; i++) wmem[i] = (mode == 0) ? v : 18'(i + 1);
   endtask

   task automatic drive(input logic en, input int x, input int y, input logic [17:0] d, input logic rnd);
      issue_en = en; issue_x = 8'(x); issue_y = 8'(y); issue_data = d; issue_round = rnd;
   endtask

   task automatic do_arm(input int cx, input int cy, input logic [1:0] r);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      arm = 1; center_x = 8'(cx); center_y = 8'(cy); radius = r;
      @(negedge clk);
      arm = 0;
   endtask

   // Waits for result_valid with a cycle budget, then compares result and releases it
   task automatic finish_round(input string name, input logic [47:0] exp);
      int cyc = 0;
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      while (!result_valid && cyc < 20) begin @(negedge clk); cyc++; end
      n_chk++;
      if (result_valid !== 1'b1) $display("FAIL %s timeout: result_valid got %0b exp 1", name, result_valid);
      else if (result !== exp) $display("FAIL %s result: got %0d exp %0d", name, $signed(result), $signed(exp));
      else n_pass++;
      result_ready = 1;
      @(negedge clk);
      result_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1; arm = 0; result_ready = 0; center_x = 0; center_y = 0; radius = 0;
      drive(0, 0, 0, 0, 0);
      wfill(0, 18'd1);
      #12;
      n_chk++;
      if ({result_valid, block_req, busy} !== 3'b000 || result !== 48'd0)
         $display("FAIL reset_state: got v=%0b b=%0b busy=%0b res=%0d exp all 0",
                  result_valid, block_req, busy, result);
      else n_pass++;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_1x1();
      wfill(0, 18'd4);
      do_arm(5, 5, 2'd0);
      drive(1, 5, 5, 18'd3, 0); #1;
      n_chk++; if (weight_addr !== 14'd0) $display("FAIL 1x1_addr_z0: got %0d exp 0", weight_addr); else n_pass++;
      @(negedge clk); drive(1, 5, 5, 18'd2, 0); #1;
      n_chk++; if (weight_addr !== 14'd1) $display("FAIL 1x1_addr_z1: got %0d exp 1", weight_addr); else n_pass++;
      @(negedge clk); drive(0, 0, 0, 0, 1);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      n_chk++; if (busy !== 1'b1 || result_valid !== 1'b0)
         $display("FAIL 1x1_drain1: got busy=%0b v=%0b exp busy=1 v=0", busy, result_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (result_valid !== 1'b0) $display("FAIL 1x1_drain2: got v=%0b exp 0", result_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (result_valid !== 1'b1 || result !== 48'd20 || block_req !== 1'b1)
         $display("FAIL 1x1_result: got v=%0b res=%0d blk=%0b exp v=1 res=20 blk=1", result_valid, result, block_req);
      else n_pass++;
      result_ready = 1;
      @(negedge clk); result_ready = 0;
      n_chk++; if (block_req !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL 1x1_release: got blk=%0b v=%0b busy=%0b exp 0", block_req, result_valid, busy); else n_pass++;
   endtask

   task automatic test_3x3_padding();
      int bad = 0;
      wfill(0, 18'd1);
      do_arm(1, 1, 2'd1);
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++) begin
            if (x != 0 || y != 0) @(negedge clk);
            drive(1, x, y, (x == 0 || y == 0) ? 18'd0 : 18'd1, (x == 2 && y == 2));
            #1;
            if (weight_addr !== 14'(y * 3 + x)) begin
               bad++;
               $display("FAIL 3x3_addr: got %0d exp %0d", weight_addr, y * 3 + x);
            end
         end
      n_chk++; if (bad == 0) n_pass++;
      finish_round("3x3_padding", 48'd4);
   endtask

   task automatic test_window_filter();
      wfill(0, 18'd1);
      do_arm(10, 10, 2'd1);
      for (int y = 8; y <= 12; y++)
         for (int x = 8; x <= 12; x++) begin
            if (x != 8 || y != 8) @(negedge clk);
            drive(1, x, y, 18'd1, 0);
         end
      @(negedge clk); drive(0, 9, 9, 18'd50, 1); #1;
      n_chk++; if (weight_addr !== 14'd9) $display("FAIL window_z1_addr: got %0d exp 9", weight_addr); else n_pass++;
      finish_round("window_filter", 48'd9);
   endtask

   // Edge window at origin with illegal radius 3 (treated as 2), negative sum, then hold
   task automatic test_handshake_hold();
      logic [47:0] exp = -48'sd49;
      wfill(1, 18'd0);
      do_arm(0, 0, 2'd3);
      drive(1, 255, 255, 18'd100, 0);
      @(negedge clk); drive(1, 0, 0, 18'd2, 0); #1;
      n_chk++; if (weight_addr !== 14'd12) $display("FAIL clamp_r_addr: got %0d exp 12", weight_addr); else n_pass++;
      @(negedge clk); drive(1, 3, 0, 18'd1000, 0);
      @(negedge clk); drive(0, 1, 1, 18'd77, 0);
      @(negedge clk); drive(1, 2, 2, -18'sd3, 1);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      @(negedge clk); @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         arm = (i == 2); center_x = 8'd40;
         n_chk++; if (result_valid !== 1'b1 || result !== exp || block_req !== 1'b1)
            $display("FAIL hold_cycle%0d: got v=%0b res=%0d blk=%0b exp v=1 res=-49 blk=1",
                     i, result_valid, $signed(result), block_req);
         else n_pass++;
         @(negedge clk);
      end
      arm = 1; result_ready = 1;
      @(negedge clk); arm = 0; result_ready = 0;
      n_chk++; if (busy !== 1'b0 || result_valid !== 1'b0 || block_req !== 1'b0)
         $display("FAIL arm_with_ready: got busy=%0b v=%0b blk=%0b exp 0", busy, result_valid, block_req);
      else n_pass++;
   endtask

   task automatic test_reset_mid_round();
      wfill(0, 18'd1);
      do_arm(5, 5, 2'd0);
      drive(1, 5, 5, 18'd10, 0);
      @(negedge clk); drive(1, 5, 5, 18'd10, 0);
      @(negedge clk); drive(1, 5, 5, 18'd10, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      #2 rst = 1;
      #1;
      n_chk++; if (busy !== 1'b0 || result_valid !== 1'b0 || block_req !== 1'b0 || result !== 48'd0)
         $display("FAIL async_reset: got busy=%0b v=%0b blk=%0b res=%0d exp 0", busy, result_valid, block_req, result);
      else n_pass++;
      @(negedge clk); rst = 0;
      do_arm(5, 5, 2'd0);
      drive(1, 5, 5, 18'd7, 1);
      finish_round("rearm_after_reset", 48'd7);
   endtask

   task automatic test_saturation();
      logic [47:0] exp;
      wfill(0, 18'h1FFFF);
      do_arm(1, 1, 2'd1);
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++) begin
            if (x != 0 || y != 0) @(negedge clk);
            drive(1, x, y, 18'h1FFFF, (x == 2 && y == 2));
         end
`ifdef PIXEL_ALLOCATOR_SATURATE_EN
      exp = 48'd131071;
      finish_round("saturate", exp);
      n_chk++; if (sat_flag !== 1'b1) $display("FAIL sat_flag: got %0b exp 1", sat_flag); else n_pass++;
`else
      exp = 48'd154616463369;
      finish_round("wide_sum", exp);
`endif
   endtask

   initial begin
      test_reset();
      test_1x1();
      test_3x3_padding();
      test_window_filter();
      test_handshake_hold();
      test_reset_mid_round();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
